// File: rtl/ascon_perm_ctrl.sv
// ascon_perm_ctrl: sequences the Ascon round function into a full permutation p^n.
//   Holds the 320-bit state {x0,x1,x2,x3,x4} (x0 in [319:256]) and applies the last
//   n rounds of the 12-round constant schedule, RPC rounds per clock (RPC = 1 or 2).
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid_i/in_ready_o request handshake; in_ready_o high while idle
//   in_rounds_i           requested round count n (clamped to 12)
//   in_state_i            input state
//   out_valid_o/out_ready_i result handshake; out_state_o is the state register
//   busy_o                high while rounds are being applied
//   abort_i               only with ASCON_ABORT_EN: drops RUN/DONE back to IDLE
// Optional feature macro: ASCON_ABORT_EN
module ascon_perm_ctrl #(
  parameter int unsigned RPC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [3:0]   in_rounds_i,
  input  logic [319:0] in_state_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [319:0] out_state_o,
  output logic         busy_o
`ifdef ASCON_ABORT_EN
  ,
  input  logic         abort_i
`endif
);

  localparam int unsigned W_STATE = 320;
  localparam int unsigned W_LANE  = 64;
  localparam int unsigned W_RND   = 4;
  localparam int unsigned W_RC    = 8;
  localparam int unsigned MAX_RND = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  function automatic logic [W_LANE-1:0] ror64(input logic [W_LANE-1:0] x, input int unsigned n);
    return (x >> n) | (x << (W_LANE - n));
  endfunction

  // Round constant for schedule index i: high nibble counts down while low nibble counts up.
  function automatic logic [W_RC-1:0] rc_of(input logic [W_RND-1:0] i);
    return {4'(4'hF - i), i};
  endfunction

  // One Ascon round: constant addition, bitsliced 5-bit S-box, linear diffusion.
  function automatic logic [W_STATE-1:0] ascon_round(input logic [W_STATE-1:0] s,
                                                     input logic [W_RC-1:0]    rc);
    logic [W_LANE-1:0] x0, x1, x2, x3, x4;
    logic [W_LANE-1:0] t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2 = x2 ^ W_LANE'(rc);
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  fsm_e               fsm_q, fsm_d;
  logic [W_STATE-1:0] state_q, state_d, step_state;
  logic [W_RND-1:0]   rnd_idx_q, rnd_idx_d, rnd_next, n_eff;
  logic [W_RC-1:0]    rc_cur;
  logic               abort_c;

`ifdef ASCON_ABORT_EN
  assign abort_c = abort_i;
`else
  assign abort_c = 1'b0;
`endif

  assign n_eff  = (in_rounds_i > W_RND'(MAX_RND)) ? W_RND'(MAX_RND) : in_rounds_i;
  assign rc_cur = rc_of(rnd_idx_q);

  // Round datapath: one or two chained rounds per edge.
  if (RPC == 1) begin : g_rpc1
    assign step_state = ascon_round(state_q, rc_cur);
    assign rnd_next   = W_RND'(rnd_idx_q + 4'd1);
  end else if (RPC == 2) begin : g_rpc2
    logic [W_STATE-1:0] r1;
    logic               two_left;
    assign r1       = ascon_round(state_q, rc_cur);
    // A single remaining round (odd n) bypasses the second instance.
    assign two_left = (W_RND'(rnd_idx_q + 4'd2) <= W_RND'(MAX_RND));
    assign step_state = two_left ? ascon_round(r1, rc_of(W_RND'(rnd_idx_q + 4'd1))) : r1;
    assign rnd_next   = two_left ? W_RND'(rnd_idx_q + 4'd2) : W_RND'(rnd_idx_q + 4'd1);
  end else begin : g_bad
    $error("ascon_perm_ctrl: RPC must be 1 or 2");
  end

  // State register of the controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= ST_IDLE;
    else     fsm_q <= fsm_d;
  end

  // Next-state logic; abort wins over completion and the output handshake.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE: if (in_valid_i) fsm_d = (n_eff == '0) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (abort_c)                             fsm_d = ST_IDLE;
        else if (rnd_next == W_RND'(MAX_RND))    fsm_d = ST_DONE;
      end
      ST_DONE: if (abort_c || out_ready_i) fsm_d = ST_IDLE;
      default: fsm_d = ST_IDLE;
    endcase
  end

  // Output decode of the registered state.
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (fsm_q)
      ST_IDLE: in_ready_o  = 1'b1;
      ST_RUN:  busy_o      = 1'b1;
      ST_DONE: out_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Permutation state and round index next values.
  always_comb begin
    state_d   = state_q;
    rnd_idx_d = rnd_idx_q;
    if (fsm_q == ST_IDLE && in_valid_i) begin
      state_d   = in_state_i;
      rnd_idx_d = W_RND'(W_RND'(MAX_RND) - n_eff);
    end else if (fsm_q == ST_RUN && !abort_c) begin
      state_d   = step_state;
      rnd_idx_d = rnd_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= '0;
      rnd_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      rnd_idx_q <= rnd_idx_d;
    end
  end

  assign out_state_o = state_q;

endmodule
